// File: rtl/mm_host_seq_pkg.sv
// mm_host_seq_pkg: shared types and constants for the matrix-multiplier host sequencer.
package mm_host_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, START, WAIT, READ, FIN} seq_state_e;
    typedef struct packed {
        logic [15:0] w_rows;
        logic [15:0] i_rows;
        logic [15:0] w_offset;
        logic [15:0] i_offset;
        logic [15:0] o_offset_w;
        logic [0:0]  extra_config;
    } data_config_struct;
    localparam int MM_DONE_GUARD = 2;
endpackage

// File: rtl/mm_host_seq_out_skid.sv
// mm_out_skid: two-entry FIFO holding output-buffer read data while the result sink stalls.
module mm_out_skid #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;
    assign valid_o = r_count != 2'd0;
    assign w_pop   = valid_o && ready_i;
    // when full, a same-cycle pop frees the slot the write pointer already points at
    assign w_push  = push_i && (r_count != 2'd2 || w_pop);
    assign data_o  = r_mem[r_rd];
    assign count_o = r_count;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= data_i;
                r_wr        <= !r_wr;
            end
            if (w_pop) r_rd <= !r_rd;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/mm_host_seq.sv
// mm_host_seq: loads weight/input buffers from a stream, runs the multiplier, streams results out.
module mm_host_seq
    import mm_host_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int OUT_W  = 32,
    parameter int W_SIZE = 256,
    parameter int I_SIZE = 256,
    parameter int O_SIZE = 256
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  data_config_struct         config_i,
    input  logic                      go_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [COL*WIDTH-1:0]      s_data_i,
    output logic                      wb_mem_cenb_o,
    output logic                      wb_mem_wenb_o,
    output logic [$clog2(W_SIZE)-1:0] wb_mem_addr_o,
    output logic [COL*WIDTH-1:0]      wb_mem_data_o,
    output logic                      ib_mem_cenb_o,
    output logic                      ib_mem_wenb_o,
    output logic [$clog2(I_SIZE)-1:0] ib_mem_addr_o,
    output logic [ROW*WIDTH-1:0]      ib_mem_data_o,
    output logic                      ob_mem_cenb_o,
    output logic                      ob_mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0] ob_mem_addr_o,
    input  logic [COL*OUT_W-1:0]      ob_mem_data_i,
    output logic                      mm_start_o,
    input  logic                      mm_done_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [COL*OUT_W-1:0]      m_data_o
);
    localparam int WA = $clog2(W_SIZE);
    localparam int IA = $clog2(I_SIZE);
    localparam int OA = $clog2(O_SIZE);
    if (ROW != COL) begin : g_row_col
        $error("mm_host_seq requires ROW == COL");
    end
    seq_state_e  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_issued;
    logic [15:0] r_acc;
    logic [1:0]  r_guard;
    logic        r_inflight;
    logic        r_busy;
    logic        r_start;
    logic        r_done;
    logic        w_load_w;
    logic        w_load_i;
    logic        w_hs;
    logic        w_beat_last;
    logic        w_issue;
    logic        w_pop;
    logic        w_read_last;
    logic [15:0] w_rows_cur;
    logic [15:0] w_n;
    logic [1:0]  w_skid_cnt;
    seq_state_e  w_after_w;
    assign w_load_w    = r_state == LOAD_W;
    assign w_load_i    = r_state == LOAD_I;
    assign s_ready_o   = w_load_w || w_load_i;
    assign w_hs        = s_valid_i && s_ready_o;
    assign w_rows_cur  = w_load_w ? config_i.w_rows : config_i.i_rows;
    assign w_beat_last = r_cnt == w_rows_cur - 16'd1;
    assign w_after_w   = config_i.i_rows != 16'd0 ? LOAD_I : START;
    assign w_n         = config_i.extra_config[0] ? 16'(ROW) : config_i.i_rows;
    assign w_pop       = m_valid_o && m_ready_i;
    // a word popped this cycle frees a slot, so issue can keep pace with an unstalled sink
    assign w_issue     = r_state == READ && r_issued < w_n &&
                         ({1'b0, w_skid_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    assign w_read_last = w_n == 16'd0 || (w_pop && r_acc == w_n - 16'd1);
    assign wb_mem_cenb_o = !(w_hs && w_load_w);
    assign wb_mem_wenb_o = wb_mem_cenb_o;
    assign wb_mem_addr_o = wb_mem_cenb_o ? '0 : WA'(config_i.w_offset + r_cnt);
    assign wb_mem_data_o = wb_mem_cenb_o ? '0 : s_data_i;
    assign ib_mem_cenb_o = !(w_hs && w_load_i);
    assign ib_mem_wenb_o = ib_mem_cenb_o;
    assign ib_mem_addr_o = ib_mem_cenb_o ? '0 : IA'(config_i.i_offset + r_cnt);
    assign ib_mem_data_o = ib_mem_cenb_o ? '0 : s_data_i;
    assign ob_mem_cenb_o = !w_issue;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = w_issue ? OA'(config_i.o_offset_w + r_issued) : '0;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign mm_start_o = r_start;
    mm_out_skid #(.W(COL*OUT_W)) u_skid (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (r_inflight),
        .data_i  (ob_mem_data_i),
        .valid_o (m_valid_o),
        .ready_i (m_ready_i),
        .data_o  (m_data_o),
        .count_o (w_skid_cnt)
    );
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_issued   <= '0;
            r_acc      <= '0;
            r_guard    <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                IDLE: if (go_i) begin
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= config_i.w_rows != 16'd0 ? LOAD_W : w_after_w;
                    r_start <= config_i.w_rows == 16'd0 && config_i.i_rows == 16'd0;
                end
                LOAD_W, LOAD_I: if (w_hs) begin
                    r_cnt <= w_beat_last ? '0 : r_cnt + 16'd1;
                    if (w_beat_last) begin
                        r_state <= w_load_w ? w_after_w : START;
                        r_start <= w_load_i || config_i.i_rows == 16'd0;
                    end
                end
                START: begin
                    r_state <= WAIT;
                    r_guard <= '0;
                end
                // the controller's done from the previous run is still high for a couple of cycles
                WAIT: if (r_guard != 2'(MM_DONE_GUARD)) r_guard <= r_guard + 2'd1;
                    else if (mm_done_i) begin
                        r_state  <= READ;
                        r_issued <= '0;
                        r_acc    <= '0;
                    end
                READ: begin
                    if (w_issue) r_issued <= r_issued + 16'd1;
                    if (w_pop) r_acc <= r_acc + 16'd1;
                    if (w_read_last) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_host_seq.sv
// tb_mm_host_seq: randomized scoreboard bench for the host sequencer.
module tb_mm_host_seq;
    import mm_host_seq_pkg::*;
    logic              clk_i = 1'b0;
    logic              rstn_i;
    data_config_struct config_i;
    logic              go_i;
    logic              busy_o;
    logic              done_o;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [31:0]       s_data_i;
    logic              wb_mem_cenb_o, wb_mem_wenb_o;
    logic [7:0]        wb_mem_addr_o;
    logic [31:0]       wb_mem_data_o;
    logic              ib_mem_cenb_o, ib_mem_wenb_o;
    logic [7:0]        ib_mem_addr_o;
    logic [31:0]       ib_mem_data_o;
    logic              ob_mem_cenb_o, ob_mem_wenb_o;
    logic [7:0]        ob_mem_addr_o;
    logic [127:0]      ob_mem_data_i = '0;
    logic              mm_start_o;
    logic              mm_done_i = 1'b1;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;
    logic [127:0]      m_data_o;

    mm_host_seq dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .config_i(config_i), .go_i(go_i),
        .busy_o(busy_o), .done_o(done_o),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .wb_mem_cenb_o(wb_mem_cenb_o), .wb_mem_wenb_o(wb_mem_wenb_o),
        .wb_mem_addr_o(wb_mem_addr_o), .wb_mem_data_o(wb_mem_data_o),
        .ib_mem_cenb_o(ib_mem_cenb_o), .ib_mem_wenb_o(ib_mem_wenb_o),
        .ib_mem_addr_o(ib_mem_addr_o), .ib_mem_data_o(ib_mem_data_o),
        .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o),
        .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_i(ob_mem_data_i),
        .mm_start_o(mm_start_o), .mm_done_i(mm_done_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [39:0]  exp_w[$];
    logic [39:0]  exp_i[$];
    logic [7:0]   exp_oba[$];
    logic [127:0] exp_out[$];
    logic [127:0] obmem [256];
    int  ready_mode = 0;
    bit  done_stuck = 1'b1;
    bit  gap_chk = 1'b0;
    bit  first_rd = 1'b0;
    int  start_cnt = 0;
    int  done_cnt = 0;
    int  start_cyc = 0;
    int  rd_n = 0;
    int  acc_n = 0;
    bit  prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic fail_msg(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected or missing event, required expected behaviour", nm);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // output buffer memory: one-cycle read latency
    always @(posedge clk_i)
        if (!ob_mem_cenb_o) ob_mem_data_i <= obmem[ob_mem_addr_o];

    // controller: done drops on start and rises after a random compute time
    initial begin
        int ctl;
        bit st;
        ctl = 0;
        forever begin
            @(negedge clk_i);
            st = mm_start_o;
            @(posedge clk_i);
            #1;
            if (done_stuck) mm_done_i = 1'b1;
            else if (st) begin
                mm_done_i = 1'b0;
                ctl = $urandom_range(3, 10);
            end else if (ctl > 0) begin
                ctl--;
                if (ctl == 0) mm_done_i = 1'b1;
            end
        end
    end

    initial begin
        int pat;
        pat = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (ready_mode == 0) m_ready_i = 1'b1;
            else if (ready_mode == 1) begin
                m_ready_i = (pat == 0 || pat == 3);
                pat = (pat + 1) % 4;
            end else m_ready_i = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk_i) begin
        bit popnow;
        if (rstn_i) begin
            if (!wb_mem_cenb_o) begin
                if (exp_w.size() == 0) fail_msg("wb_write_extra");
                else chk("wb_write", {wb_mem_wenb_o, wb_mem_addr_o, wb_mem_data_o}, {1'b0, exp_w.pop_front()});
            end
            if (!ib_mem_cenb_o) begin
                if (exp_i.size() == 0) fail_msg("ib_write_extra");
                else chk("ib_write", {ib_mem_wenb_o, ib_mem_addr_o, ib_mem_data_o}, {1'b0, exp_i.pop_front()});
            end
            popnow = m_valid_o && m_ready_i;
            if (!ob_mem_cenb_o) begin
                if (first_rd) begin
                    first_rd = 1'b0;
                    if (gap_chk) chk("start_to_read", cyc - start_cyc, 4);
                    chk("done_before_read", mm_done_i, 1);
                end
                if (exp_oba.size() == 0) fail_msg("ob_read_extra");
                else chk("ob_read", {ob_mem_wenb_o, ob_mem_addr_o}, {1'b1, exp_oba.pop_front()});
                chk("outstanding", (rd_n - acc_n + 1 - int'(popnow)) <= 2, 1);
                rd_n++;
            end
            if (popnow) begin
                acc_n++;
                if (exp_out.size() == 0) fail_msg("m_data_extra");
                else chk("m_data", m_data_o, exp_out.pop_front());
            end
            if (prev_stall) chk("m_hold", {m_valid_o, m_data_o}, {1'b1, prev_data});
            prev_stall = m_valid_o && !m_ready_i;
            prev_data = m_data_o;
            if (mm_start_o) begin
                start_cnt++;
                start_cyc = cyc;
                first_rd = 1'b1;
            end
            if (done_o) done_cnt++;
        end else prev_stall = 1'b0;
    end

    task automatic chk_reset(input string t);
        chk({t, "_ctl"}, {busy_o, done_o, mm_start_o, s_ready_o, m_valid_o}, 5'b0);
        chk({t, "_enb"}, {wb_mem_cenb_o, wb_mem_wenb_o, ib_mem_cenb_o, ib_mem_wenb_o, ob_mem_cenb_o, ob_mem_wenb_o}, 6'h3f);
        chk({t, "_addr"}, {wb_mem_addr_o, ib_mem_addr_o, ob_mem_addr_o}, 0);
        chk({t, "_data"}, {wb_mem_data_o, ib_mem_data_o, m_data_o}, 0);
    endtask

    task automatic run(input int wr, input int ir, input int wo, input int io, input int oo,
                       input bit os, input int rmode, input bit stuck, input bit gaps,
                       input bit rgo, input bit rst_mid);
        data_config_struct cfg;
        logic [31:0] beats[$];
        logic [31:0] d;
        int n, b;
        bit ok;
        cfg = '0;
        cfg.w_rows = 16'(wr);
        cfg.i_rows = 16'(ir);
        cfg.w_offset = 16'(wo);
        cfg.i_offset = 16'(io);
        cfg.o_offset_w = 16'(oo);
        cfg.extra_config[0] = os;
        config_i = cfg;
        ready_mode = rmode;
        done_stuck = stuck;
        gap_chk = stuck;
        n = os ? 4 : ir;
        for (int k = 0; k < wr; k++) begin
            d = $urandom;
            beats.push_back(d);
            exp_w.push_back({8'(wo + k), d});
        end
        for (int k = 0; k < ir; k++) begin
            d = $urandom;
            beats.push_back(d);
            exp_i.push_back({8'(io + k), d});
        end
        for (int r = 0; r < n; r++) begin
            exp_oba.push_back(8'(oo + r));
            exp_out.push_back(obmem[8'(oo + r)]);
        end
        start_cnt = 0;
        done_cnt = 0;
        @(posedge clk_i);
        #1;
        go_i = 1'b1;
        s_valid_i = beats.size() > 0;
        s_data_i = beats.size() > 0 ? beats[0] : 32'h0;
        @(posedge clk_i);
        #1;
        go_i = 1'b0;
        chk("busy_after_go", busy_o, 1);
        if (wr == 0 && ir == 0) chk("zero_len_start", mm_start_o, 1);
        for (int k = 0; k < beats.size(); k++) begin
            if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin
                s_valid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
            s_valid_i = 1'b1;
            s_data_i = beats[k];
            b = 0;
            do begin
                @(negedge clk_i);
                ok = s_ready_o;
                @(posedge clk_i);
                #1;
                b++;
            end while (!ok && b < 100);
            if (!ok) fail_msg("s_ready_timeout");
        end
        s_valid_i = 1'b0;
        if (rst_mid) begin
            b = 0;
            do begin
                @(negedge clk_i);
                b++;
            end while (!m_valid_o && b < 200);
            if (!m_valid_o) fail_msg("read_phase_timeout");
            @(posedge clk_i);
            #1;
            rstn_i = 1'b0;
            @(negedge clk_i);
            chk_reset("mid_reset");
            exp_w.delete();
            exp_i.delete();
            exp_oba.delete();
            exp_out.delete();
            rd_n = 0;
            acc_n = 0;
            first_rd = 1'b0;
            @(posedge clk_i);
            #1;
            rstn_i = 1'b1;
        end else begin
            b = 0;
            do begin
                @(posedge clk_i);
                #1;
                if (rgo) go_i = ($urandom_range(0, 3) == 0);
                @(negedge clk_i);
                b++;
            end while (!done_o && b < 1000);
            go_i = 1'b0;
            if (!done_o) fail_msg("done_timeout");
            @(posedge clk_i);
            #1;
            chk("done_pulse_end", {done_o, busy_o}, 2'b00);
            chk("start_pulses", start_cnt, 1);
            chk("done_pulses", done_cnt, 1);
            chk("queues_drained", exp_w.size() + exp_i.size() + exp_oba.size() + exp_out.size(), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0;
        go_i = 1'b0;
        s_valid_i = 1'b0;
        s_data_i = '0;
        config_i = '0;
        for (int a = 0; a < 256; a++) obmem[a] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset("reset");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        run(4, 6, 0, 16, 32, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4, 3, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(2, 8, 100, 40, 7, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        run(0, 0, 5, 5, 9, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3, 4, 253, 254, 254, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6)
            run($urandom_range(0, 6), $urandom_range(0, 8), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
        run(2, 5, 10, 20, 30, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        run(3, 5, 60, 70, 80, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
